// File: rtl/laser_pixel_sink.sv
// laser_pixel_sink: Avalon-MM pixel write sink that finds the strongest laser-red pixel per frame
module laser_pixel_sink #(
    parameter logic [31:0] BASE_ADDR = 32'h0800_0000,
    parameter int          WIDTH     = 320,
    parameter int          HEIGHT    = 240,
    parameter int          XBITS     = 9,
    parameter int          YBITS     = 8,
    parameter int          FIFO_AW   = 2
) (
    input  logic             clk_clk,
    input  logic             reset_reset_n,
    input  logic [31:0]      avs_address,
    input  logic             avs_write,
    input  logic [31:0]      avs_writedata,
    output logic             avs_waitrequest,
    input  logic             proc_en,
    input  logic [7:0]       threshold,
    output logic [XBITS-1:0] laser_x,
    output logic [YBITS-1:0] laser_y,
    output logic             laser_found,
    output logic             frame_done
);
    localparam int EW    = XBITS + YBITS + 25;
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [XBITS-1:0] XLAST = XBITS'(WIDTH - 1);
    localparam logic [YBITS-1:0] YLAST = YBITS'(HEIGHT - 1);
    logic [EW-1:0] mem [DEPTH];
    logic [EW-1:0] head;
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0] count, count_nx;
    logic [XBITS+YBITS-1:0] off_w;
    logic [XBITS-1:0] in_x, s1_x, cand_x;
    logic [YBITS-1:0] in_y, s1_y, cand_y;
    logic in_rng, push, pop, s1_valid, s1_rng, pub_pend, any_hit, eff_hit, cand, last;
    logic [8:0] gb_sum, diff;
    logic [7:0] score, s1_score, max_score, eff_max;
    logic unused;
    assign unused = ^{avs_writedata[31:24], avs_address[1:0]};
    assign off_w = avs_address[XBITS+YBITS+1:2] - BASE_ADDR[XBITS+YBITS+1:2];
    assign in_x = off_w[XBITS-1:0];
    assign in_y = off_w[XBITS+YBITS-1:XBITS];
    assign in_rng = avs_address >= BASE_ADDR && in_x <= XLAST && in_y <= YLAST;
    assign push = avs_write && !avs_waitrequest;
    assign pop = count != '0 && proc_en;
    assign count_nx = count + {{FIFO_AW{1'b0}}, push} - {{FIFO_AW{1'b0}}, pop};
    assign head = mem[rd_ptr];
    assign gb_sum = {1'b0, head[15:8]} + {1'b0, head[7:0]};
    assign diff = {1'b0, head[23:16]} - {1'b0, gb_sum[8:1]};
    assign score = diff[8] ? 8'd0 : diff[7:0];
    // A publish in flight clears the accumulators for the pixel arriving in the same cycle
    assign eff_max = pub_pend ? 8'd0 : max_score;
    assign eff_hit = pub_pend ? 1'b0 : any_hit;
    assign cand = s1_valid && s1_rng && s1_score >= threshold && s1_score > eff_max;
    assign last = s1_valid && s1_rng && s1_x == XLAST && s1_y == YLAST;
    always_ff @(posedge clk_clk)
        if (push) mem[wr_ptr] <= {in_x, in_y, in_rng, avs_writedata[23:0]};
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            avs_waitrequest <= 1'b1;
            count <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            s1_valid <= 1'b0;
            s1_rng <= 1'b0;
            s1_x <= '0;
            s1_y <= '0;
            s1_score <= '0;
            pub_pend <= 1'b0;
            max_score <= '0;
            any_hit <= 1'b0;
            cand_x <= '0;
            cand_y <= '0;
            laser_x <= '0;
            laser_y <= '0;
            laser_found <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            count <= count_nx;
            avs_waitrequest <= count_nx == (FIFO_AW+1)'(DEPTH);
            wr_ptr <= wr_ptr + FIFO_AW'(push);
            rd_ptr <= rd_ptr + FIFO_AW'(pop);
            s1_valid <= pop;
            if (pop) {s1_x, s1_y, s1_rng, s1_score} <= {head[EW-1 -: XBITS], head[24+YBITS -: YBITS], head[24], score};
            pub_pend <= last;
            max_score <= cand ? s1_score : eff_max;
            any_hit <= cand || eff_hit;
            if (cand) {cand_x, cand_y} <= {s1_x, s1_y};
            frame_done <= pub_pend;
            if (pub_pend) begin
                laser_found <= any_hit;
                if (any_hit) {laser_x, laser_y} <= {cand_x, cand_y};
            end
        end
    end
endmodule

// File: tb/tb_laser_pixel_sink.sv
// tb_laser_pixel_sink: scoreboard bench comparing frame results against a per-frame reference model
module tb_laser_pixel_sink;
    localparam logic [31:0] BASE = 32'h0800_0000;
    logic clk = 0, rst_n = 0, wr = 0, proc_en = 1, wreq, lf, fd;
    logic [31:0] addr = 0, wdata = 0;
    logic [7:0] thr = 8'h40, ly;
    logic [8:0] lx;
    typedef struct {int x; int y; int found; int due;} exp_t;
    exp_t q[$];
    exp_t e;
    int errors = 0, checks = 0, ncnt = 0, last_wait = 0;
    int best = 0, bx = 0, by = 0, found = 0, px = 0, py = 0;
    bit want_lat = 0, rnd_pe = 0;

    laser_pixel_sink dut (
        .clk_clk(clk), .reset_reset_n(rst_n), .avs_address(addr), .avs_write(wr),
        .avs_writedata(wdata), .avs_waitrequest(wreq), .proc_en(proc_en), .threshold(thr),
        .laser_x(lx), .laser_y(ly), .laser_found(lf), .frame_done(fd)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pa(input int x, input int y);
        return BASE + 32'(y * 2048) + 32'(x * 4);
    endfunction

    // Reference: best pixel of the frame so far; the last pixel closes the frame
    task automatic model_pixel(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] off;
        int x, y, s;
        bit inr;
        off = a - BASE;
        x = int'(off >> 2) % 512;
        y = int'(off >> 11) % 256;
        inr = a >= BASE && x < 320 && y < 240;
        s = int'(d[23:16]) - (int'(d[15:8]) + int'(d[7:0])) / 2;
        if (s < 0) s = 0;
        if (inr && s >= int'(thr) && s > best) begin
            best = s; bx = x; by = y; found = 1;
        end
        if (inr && x == 319 && y == 239) begin
            if (found) begin px = bx; py = by; end
            q.push_back('{px, py, found, want_lat ? ncnt + 4 : -1});
            best = 0;
            found = 0;
        end
    endtask

    task automatic wr_px(input logic [31:0] a, input logic [31:0] d);
        int n = 0;
        bit ok = 0;
        addr = a; wdata = d; wr = 1;
        while (!ok && n < 200) begin
            ok = !wreq;
            tick(1);
            n++;
        end
        wr = 0;
        last_wait = n;
        if (!ok) begin
            checks++; errors++;
            $display("FAIL write_accept: got stalled expected accept within 200 cycles");
        end else model_pixel(a, d);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            tick(1);
            n++;
        end
        check("drain_pending_frames", q.size(), 0);
        tick(3);
    endtask

    always @(negedge clk) begin
        ncnt++;
        if (rst_n && fd) begin
            if (q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_frame_done: got pulse expected none");
            end else begin
                e = q.pop_front();
                check("laser_x", int'(lx), e.x);
                check("laser_y", int'(ly), e.y);
                check("laser_found", int'(lf), e.found);
                if (e.due >= 0) check("frame_done_latency", ncnt, e.due);
            end
        end
    end

    always @(posedge clk)
        if (rnd_pe) begin
            #1;
            proc_en = $urandom_range(0, 2) != 0;
        end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int acc, n;
        bit ok;
        repeat (2) @(posedge clk);
        #1;
        check("rst_waitrequest", int'(wreq), 1);
        check("rst_laser_x", int'(lx), 0);
        check("rst_laser_y", int'(ly), 0);
        check("rst_laser_found", int'(lf), 0);
        check("rst_frame_done", int'(fd), 0);
        rst_n = 1;
        tick(1);
        check("waitrequest_after_release", int'(wreq), 0);
        wr_px(pa(0, 0), 32'h00FF_0000);
        check("first_write_no_stall", last_wait, 1);
        wr_px(pa(319, 239), 32'h0010_1010);
        drain();
        for (int i = 1; i <= 30; i++) wr_px(pa((i * 37) % 320, (i * 11) % 240), 32'h0010_1010);
        wr_px(pa(100, 50), 32'h00F0_1010);
        for (int i = 31; i <= 40; i++) wr_px(pa((i * 37) % 320, (i * 11) % 240), 32'h0010_1010);
        tick(3);
        want_lat = 1;
        wr_px(pa(319, 239), 32'h0010_1010);
        want_lat = 0;
        drain();
        wr_px(pa(10, 5), 32'h00E0_0000);
        wr_px(pa(200, 100), 32'h00E0_0000);
        wr_px(pa(319, 239), 32'h0000_0000);
        drain();
        thr = 8'h80;
        for (int i = 0; i < 5; i++) wr_px(pa(i * 50, i * 40), 32'h007F_0000);
        wr_px(pa(319, 239), 32'h0000_0000);
        drain();
        thr = 8'h40;
        proc_en = 0;
        wr_px(pa(20, 20), 32'h0050_0000);
        check("fill1_no_stall", last_wait, 1);
        wr_px(pa(21, 20), 32'h0060_0000);
        check("fill2_no_stall", last_wait, 1);
        wr_px(pa(22, 20), 32'h0090_0000);
        check("fill3_no_stall", last_wait, 1);
        wr_px(pa(23, 20), 32'h0070_0000);
        check("fill4_no_stall", last_wait, 1);
        check("full_waitrequest", int'(wreq), 1);
        addr = pa(319, 239); wdata = 32'h0000_0000; wr = 1;
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            if (!wreq) acc++;
            tick(1);
        end
        check("accepts_while_full", acc, 0);
        proc_en = 1;
        n = 0; ok = 0;
        while (!ok && n < 20) begin
            ok = !wreq;
            tick(1);
            n++;
        end
        wr = 0;
        check("waitrequest_release_edges", n, 2);
        if (ok) model_pixel(pa(319, 239), 32'h0000_0000);
        drain();
        wr_px(BASE - 32'd4, 32'h00FF_0000);
        check("below_base_accepted", last_wait, 1);
        wr_px(pa(320, 0), 32'h00FF_0000);
        wr_px(pa(3, 3), 32'h0050_0000);
        wr_px(pa(319, 239), 32'h0000_0000);
        drain();
        wr_px(pa(50, 60), 32'h00FF_0000);
        tick(4);
        rst_n = 0;
        tick(1);
        check("midreset_waitrequest", int'(wreq), 1);
        check("midreset_laser_x", int'(lx), 0);
        check("midreset_laser_y", int'(ly), 0);
        check("midreset_laser_found", int'(lf), 0);
        best = 0; found = 0; px = 0; py = 0;
        rst_n = 1;
        tick(1);
        wr_px(pa(5, 5), 32'h0020_0000);
        wr_px(pa(319, 239), 32'h0000_0000);
        drain();
        rnd_pe = 1;
        for (int f = 0; f < 25; f++) begin
            thr = 8'($urandom_range(16, 192));
            for (int i = 0; i < int'($urandom_range(1, 8)); i++) begin
                logic [31:0] a;
                a = ($urandom_range(0, 9) == 0) ? BASE - 32'($urandom_range(1, 100) * 4)
                                                : pa($urandom_range(0, 339), $urandom_range(0, 249));
                wr_px(a, {8'($urandom), 8'($urandom_range(0, 255)),
                          8'($urandom_range(0, 255) >> $urandom_range(0, 4)),
                          8'($urandom_range(0, 255) >> $urandom_range(0, 4))});
            end
            wr_px(pa(319, 239), {8'($urandom), 8'($urandom_range(0, 255)), 16'($urandom)});
            drain();
        end
        rnd_pe = 0;
        tick(1);
        proc_en = 1;
        tick(5);
        check("final_queue_empty", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/laser_pixel_sink.md
Name: laser_pixel_sink

Overview:
- Avalon-MM write responder (slave) that terminates the video DMA controller's pixel-write master port.
- Buffers incoming pixel writes in a small FIFO and decodes X-Y addresses into pixel coordinates.
- Scores each pixel for laser-red content and tracks the strongest pixel over each frame.
- At frame end, publishes the laser coordinates and a found flag to the paint logic/Nios.

Parameters:
- BASE_ADDR, 32'h0800_0000, byte address of pixel (0,0)
- WIDTH, 320, pixels per line
- HEIGHT, 240, lines per frame
- XBITS, 9, x field width in address (X-Y addressing)
- YBITS, 8, y field width in address
- FIFO_AW, 2, log2 of FIFO depth (depth 4)

Ports:
- clk_clk  in  1  system clock
- reset_reset_n  in  1  asynchronous active-low reset
- avs_address  in  32  byte address from DMA master
- avs_write  in  1  write request
- avs_writedata  in  32  pixel: [23:16] R, [15:8] G, [7:0] B, [31:24] ignored
- avs_waitrequest  out  1  stall to master
- proc_en  in  1  back-end enable; 0 pauses FIFO drain
- threshold  in  8  minimum score for a laser candidate
- laser_x  out  XBITS  x of strongest pixel, last completed frame
- laser_y  out  YBITS  y of strongest pixel, last completed frame
- laser_found  out  1  1 if any pixel in last frame met threshold
- frame_done  out  1  one-cycle pulse when a frame result is published

Behaviour:
- Reset (async, reset_reset_n=0):
  - avs_waitrequest=1.
  - FIFO empty; pipeline valids 0; accumulators cleared.
  - laser_x=0, laser_y=0, laser_found=0, frame_done=0.
  - First edge after release: avs_waitrequest=0 (FIFO empty).
- Handshake:
  - A write is accepted on an edge where avs_write=1 and avs_waitrequest=0.
  - avs_waitrequest = FIFO full, driven from registered count only (no combinational path from avs_write).
  - While stalled, the master holds address/data; nothing is captured.
- FIFO entry = {x, y, in_range, R, G, B}.
  - offset = avs_address - BASE_ADDR; x = offset[XBITS+1:2]; y = offset[XBITS+YBITS+1:XBITS+2].
  - in_range = 1 when avs_address >= BASE_ADDR and x < WIDTH and y < HEIGHT.
  - Out-of-range writes are accepted, then dropped at stage 2.
- Simultaneous push/pop when full:
  - Pop frees a slot but waitrequest stays 1 that cycle (registered).
  - Count stays constant on a simultaneous push/pop.
- Stage 1 (pop):
  - Pops one entry per cycle when non-empty and proc_en=1.
  - Registers score = max(0, R - ((G+B)>>1)), 8-bit, using a 9-bit intermediate with saturation.
- Stage 2 (update, idle/ACCUM per frame):
  - Candidate when in_range and score >= threshold (threshold used live) and score > max_score.
    - Strict ">": on ties the earliest pixel wins.
    - On a candidate, latch max_score, cand_x, cand_y; set any_hit.
  - Last pixel = in_range with x==WIDTH-1 and y==HEIGHT-1.
    - Publish the candidate set including this pixel's own contribution to laser_x, laser_y, laser_found=any_hit.
    - frame_done pulses 1 cycle; same cycle, clear max_score=0, any_hit=0.
    - laser_x/laser_y hold the previous value if not found.
- Latency: accept edge of last pixel to frame_done high = 3 cycles with FIFO empty and proc_en=1.
- Pixels after a missing last pixel accumulate into the next frame; no timeout.
- proc_en=0:
  - Stage 1 halts; stage 2 completes its in-flight entry.
  - FIFO fills; waitrequest asserts at 4 entries.
- Reset mid-frame: partial accumulation discarded; outputs return to reset values.

Test Plan:
- Reset release, write pixel (0,0) data 0x00FF0000, threshold 0x40 -> avs_waitrequest 1 during reset, 0 on first edge after; write accepted with no stall.
- Full frame of 0x00101010 except (100,50)=0x00F01010 -> frame_done pulses once 3 cycles after last-pixel accept; laser_x=100, laser_y=50, laser_found=1.
- Two pixels score 0xE0 at (10,5) then (200,100) -> laser_x=10, laser_y=5 (tie keeps first).
- Frame with all scores < threshold 0x80 -> laser_found=0; laser_x/y unchanged from previous frame.
- proc_en=0, master writes continuously -> 4 accepted, then avs_waitrequest=1; proc_en=1 -> drains one per cycle, waitrequest falls one cycle after first pop, no data lost or duplicated.
- Write to BASE_ADDR-4 and to x=320 with score 0xFF -> accepted, never selected; assert reset mid-frame -> outputs 0, next frame result independent of the partial one.
